fmq_cmd_decoder: RTL and testbench
==================================

Name: fmq_cmd_decoder

Overview:
- Framed command decoder between the UART receive/transmit AXI-stream ports and the transducer-array control registers.
- Assembles 3-byte commands from the 8-bit rx stream, validates framing and channel range, and emits single-cycle write strobes for phase-offset, reload and DAC registers.
- Produces reply bytes on the tx stream.
- Adds resynchronisation, inter-byte timeout and an error counter to the bare shift-buffer scheme.

Parameters:
- OUTPUTS, 88, number of transducer channels; channels >= OUTPUTS are rejected.
- OFFSET_WIDTH, 11, offset field width; ofs_data is OFFSET_WIDTH+1 bits (enable bit at MSB).
- CH_WIDTH, 7, channel index width.
- TIMEOUT, 65535, idle clk cycles mid-frame before the partial frame is abandoned.
- TO_WIDTH, 16, timeout counter width.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  rx byte valid.
- rx_ready  out  1  decoder accepts rx byte.
- tx_data  out  8  reply byte.
- tx_valid  out  1  reply valid.
- tx_ready  in  1  UART transmitter accepts reply.
- ofs_wr  out  1  one-cycle offset write strobe.
- ofs_ch  out  CH_WIDTH  offset target channel.
- ofs_data  out  OFFSET_WIDTH+1  {enable, offset}.
- reload_req  out  1  one-cycle reload request.
- dac_wr  out  1  one-cycle DAC register write.
- dac_sel  out  1  0 = DAC value, 1 = DAC clock divisor.
- dac_data  out  8  DAC write data.
- err_count  out  8  saturating framing/range error count.
- busy  out  1  high while a frame is partially received.

Behaviour:
- Reset (rst low, async): all outputs 0 except rx_ready; state IDLE; timeout counter 0; err_count 0. rx_ready equals !tx_valid at all times, so it is 1 during reset.
- Byte accepted on a clk edge with rx_valid && rx_ready. rx_ready = !tx_valid: no bytes are accepted while a reply is pending.
- Frame format:
  - Header byte: bit7 = 1, bits[6:5] = opcode, bits[4:0] = H.
  - Byte1: bit7 = 0, bits[6:0] = B1.
  - Byte2: bit7 = 0, bits[6:0] = B2.
- State machine: IDLE -> HDR (header accepted) -> B1 (byte1 accepted) -> IDLE (byte2 accepted, execute). busy = (state != IDLE).
- Boundary rules:
  - Header byte (bit7 = 1) accepted in HDR or B1: err_count += 1; byte becomes the new header; state HDR.
  - Data byte (bit7 = 0) accepted in IDLE: discarded; err_count += 1.
  - Timeout counter clears on every accepted byte and increments each cycle in HDR or B1. On reaching TIMEOUT: state IDLE, err_count += 1, counter 0.
  - err_count saturates at 255. A same-cycle increment and clear (see opcode 10) results in 0.
- Execute, registered; strobes high for exactly the one cycle after byte2 is accepted:
  - Opcode 00, offset write: ch = {H, B1[6:5]}; data = {B1[4:0], B2}.
    - ch < OUTPUTS: ofs_wr = 1, ofs_ch = ch, ofs_data = data.
    - Otherwise: no strobe, err_count += 1.
  - Opcode 01: reload_req = 1. Payload ignored.
  - Opcode 10, query:
    - H[0] = 0: tx_data = OUTPUTS[7:0].
    - H[0] = 1: tx_data = err_count, then err_count cleared.
    - tx_valid = 1 in the execute cycle; held with tx_data stable until tx_ready, then cleared the same edge.
  - Opcode 11: dac_wr = 1, dac_sel = H[4], dac_data = {B1[0], B2}.
- ofs_ch, ofs_data, dac_sel and dac_data hold their last values between strobes.
- Reset mid-frame or with a reply pending: frame and reply are discarded; no strobe is emitted.

Test Plan:
- Offset write: bytes 0x81, 0x32, 0x55 -> single ofs_wr pulse, ofs_ch = 5, ofs_data = 0x955; err_count = 0.
- Reload and DAC writes:
  - 0xA0, 0x00, 0x00 -> one reload_req pulse.
  - 0xE0, 0x01, 0x7F -> dac_wr, dac_sel = 0, dac_data = 0xFF.
  - 0xF0, 0x00, 0x40 -> dac_wr, dac_sel = 1, dac_data = 0x40.
- Query with backpressure: 0xC0, 0x00, 0x00 with tx_ready held low 20 cycles -> tx_valid = 1, tx_data = 0x58 stable, rx_ready = 0 throughout; tx_valid drops the cycle tx_ready is seen.
- Range and resync:
  - 0x99, 0x00, 0x00 (ch 100) -> no ofs_wr, err_count = 1.
  - Then 0x81, 0xA0, 0x00, 0x00 -> reload_req, err_count = 2.
  - Then query 0xC1 -> tx_data = 0x02, err_count = 0.
- Timeout with TIMEOUT = 100: send 0x81, idle 100 cycles -> busy falls, err_count = 1. Then 0x32, 0x55 -> discarded, err_count = 3, no ofs_wr.
- Async reset asserted after 0x81, 0x32 -> all outputs cleared immediately. After release, 0x55 -> err_count = 1, no strobe.

Source files
------------

// File: rtl/fmq_cmd_decoder.sv
// Framed 3-byte command decoder sitting between the UART AXI-stream ports and the
// transducer-array control registers (phase offsets, reload, DAC), with reply bytes.
module fmq_cmd_decoder #(
  parameter int OUTPUTS      = 88,
  parameter int OFFSET_WIDTH = 11,
  parameter int CH_WIDTH     = 7,
  parameter int TIMEOUT      = 65535,
  parameter int TO_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  ofs_wr,
  output logic [CH_WIDTH-1:0]   ofs_ch,
  output logic [OFFSET_WIDTH:0] ofs_data,
  output logic                  reload_req,
  output logic                  dac_wr,
  output logic                  dac_sel,
  output logic [7:0]            dac_data,
  output logic [7:0]            err_count,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    B1   = 2'd2
  } state_e;

  localparam int                  OfsW        = OFFSET_WIDTH + 1;
  localparam logic [7:0]          OutputsByte = 8'(OUTPUTS);
  localparam logic [TO_WIDTH-1:0] ToLast      = TO_WIDTH'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [6:0]            hdr_q, hdr_d;
  logic [6:0]            b1_q, b1_d;
  logic [TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]            err_q, err_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  ofs_wr_q, ofs_wr_d;
  logic [CH_WIDTH-1:0]   ofs_ch_q, ofs_ch_d;
  logic [OfsW-1:0]       ofs_data_q, ofs_data_d;
  logic                  reload_q, reload_d;
  logic                  dac_wr_q, dac_wr_d;
  logic                  dac_sel_q, dac_sel_d;
  logic [7:0]            dac_data_q, dac_data_d;

  logic                  accept;
  logic                  execute;
  logic                  frame_err;
  logic                  range_err;
  logic                  err_clr;
  logic [1:0]            opcode;
  logic [4:0]            h_field;
  logic [6:0]            ch_w;
  logic                  ch_ok;

  // A pending reply blocks the receiver so replies can never be overrun.
  assign accept  = rx_valid && !tx_valid_q;
  assign opcode  = hdr_q[6:5];
  assign h_field = hdr_q[4:0];
  assign ch_w    = {h_field, b1_q[6:5]};
  assign ch_ok   = int'(ch_w) < OUTPUTS;

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    b1_d      = b1_q;
    to_cnt_d  = to_cnt_q;
    execute   = 1'b0;
    frame_err = 1'b0;
    if (accept) begin
      to_cnt_d = '0;
      if (rx_data[7]) begin
        // A header always restarts the frame; mid-frame it also counts as an error.
        frame_err = (state_q != IDLE);
        hdr_d     = rx_data[6:0];
        state_d   = HDR;
      end else begin
        unique case (state_q)
          IDLE: frame_err = 1'b1;
          HDR: begin
            b1_d    = rx_data[6:0];
            state_d = B1;
          end
          B1: begin
            execute = 1'b1;
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (state_q != IDLE) begin
      if (to_cnt_q == ToLast) begin
        state_d   = IDLE;
        to_cnt_d  = '0;
        frame_err = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_WIDTH'(1);
      end
    end
  end

  // Command execution; byte2 is taken straight from rx_data on its accept edge.
  always_comb begin
    ofs_wr_d   = 1'b0;
    reload_d   = 1'b0;
    dac_wr_d   = 1'b0;
    ofs_ch_d   = ofs_ch_q;
    ofs_data_d = ofs_data_q;
    dac_sel_d  = dac_sel_q;
    dac_data_d = dac_data_q;
    tx_valid_d = tx_valid_q && !tx_ready;
    tx_data_d  = tx_data_q;
    range_err  = 1'b0;
    err_clr    = 1'b0;
    if (execute) begin
      unique case (opcode)
        2'b00: begin
          if (ch_ok) begin
            ofs_wr_d   = 1'b1;
            ofs_ch_d   = CH_WIDTH'(ch_w);
            ofs_data_d = OfsW'({b1_q[4:0], rx_data[6:0]});
          end else begin
            range_err = 1'b1;
          end
        end
        2'b01: reload_d = 1'b1;
        2'b10: begin
          tx_valid_d = 1'b1;
          if (h_field[0]) begin
            tx_data_d = err_q;
            err_clr   = 1'b1;
          end else begin
            tx_data_d = OutputsByte;
          end
        end
        default: begin
          dac_wr_d   = 1'b1;
          dac_sel_d  = h_field[4];
          dac_data_d = {b1_q[0], rx_data[6:0]};
        end
      endcase
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at 255.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = '0;
    end else if ((frame_err || range_err) && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      hdr_q      <= '0;
      b1_q       <= '0;
      to_cnt_q   <= '0;
      err_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      ofs_wr_q   <= 1'b0;
      ofs_ch_q   <= '0;
      ofs_data_q <= '0;
      reload_q   <= 1'b0;
      dac_wr_q   <= 1'b0;
      dac_sel_q  <= 1'b0;
      dac_data_q <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      b1_q       <= b1_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      ofs_wr_q   <= ofs_wr_d;
      ofs_ch_q   <= ofs_ch_d;
      ofs_data_q <= ofs_data_d;
      reload_q   <= reload_d;
      dac_wr_q   <= dac_wr_d;
      dac_sel_q  <= dac_sel_d;
      dac_data_q <= dac_data_d;
    end
  end

  assign rx_ready   = !tx_valid_q;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign ofs_wr     = ofs_wr_q;
  assign ofs_ch     = ofs_ch_q;
  assign ofs_data   = ofs_data_q;
  assign reload_req = reload_q;
  assign dac_wr     = dac_wr_q;
  assign dac_sel    = dac_sel_q;
  assign dac_data   = dac_data_q;
  assign err_count  = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fmq_cmd_decoder.sv
// Directed bench for fmq_cmd_decoder: a table of whole frames with hand-computed
// results, then hand-written backpressure, resync, timeout and reset sequences.
module tb_fmq_cmd_decoder;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic        ofsWr;
    logic [6:0]  ofsCh;
    logic [11:0] ofsData;
    logic        reload;
    logic        dacWr;
    logic        dacSel;
    logic [7:0]  dacData;
    logic        txValid;
    logic [7:0]  txData;
    logic [7:0]  errCount;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic        ofsWr;
  logic [6:0]  ofsCh;
  logic [11:0] ofsData;
  logic        reloadReq;
  logic        dacWr;
  logic        dacSel;
  logic [7:0]  dacData;
  logic [7:0]  errCount;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int ofsPulses = 0;
  int reloadPulses = 0;
  int dacPulses = 0;

  vec_t vecs[9];

  fmq_cmd_decoder #(
    .OUTPUTS(88),
    .OFFSET_WIDTH(11),
    .CH_WIDTH(7),
    .TIMEOUT(100),
    .TO_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rxData),
    .rx_valid(rxValid),
    .rx_ready(rxReady),
    .tx_data(txData),
    .tx_valid(txValid),
    .tx_ready(txReady),
    .ofs_wr(ofsWr),
    .ofs_ch(ofsCh),
    .ofs_data(ofsData),
    .reload_req(reloadReq),
    .dac_wr(dacWr),
    .dac_sel(dacSel),
    .dac_data(dacData),
    .err_count(errCount),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobes are one cycle wide, so a falling-edge sample catches each one exactly once.
  always @(negedge clk) begin
    if (ofsWr === 1'b1) ofsPulses++;
    if (reloadReq === 1'b1) reloadPulses++;
    if (dacWr === 1'b1) dacPulses++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Presents one byte and returns 1ns after the edge that accepted it.
  task automatic sendByte(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    rxData  = b;
    rxValid = 1'b1;
    while (rxReady !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      checkOutput("rxReadyTimeout", 32'(rxReady), 32'd1);
    end
    @(posedge clk);
    #1;
    rxValid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2);
    sendByte(b0);
    sendByte(b1);
    sendByte(b2);
  endtask

  initial begin
    logic holdBad;
    int   ofsBefore;
    int   relBefore;
    int   dacBefore;

    //             b0     b1     b2    ofsWr ofsCh  ofsData  rel   dacWr dacSel dacData txV  txData err
    vecs[0] = '{8'h81, 8'h32, 8'h55, 1'b1, 7'd5,  12'h955, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0};
    vecs[1] = '{8'hA0, 8'h00, 8'h00, 1'b0, 7'd5,  12'h955, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0};
    vecs[2] = '{8'hE0, 8'h01, 8'h7F, 1'b0, 7'd5,  12'h955, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 8'h00, 8'd0};
    vecs[3] = '{8'hF0, 8'h00, 8'h40, 1'b0, 7'd5,  12'h955, 1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 8'd0};
    vecs[4] = '{8'h95, 8'h7F, 8'h7F, 1'b1, 7'd87, 12'hFFF, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 8'd0};
    vecs[5] = '{8'h96, 8'h00, 8'h00, 1'b0, 7'd87, 12'hFFF, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 8'd1};
    vecs[6] = '{8'h99, 8'h00, 8'h00, 1'b0, 7'd87, 12'hFFF, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 8'd2};
    vecs[7] = '{8'hC1, 8'h00, 8'h00, 1'b0, 7'd87, 12'hFFF, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1, 8'h02, 8'd0};
    vecs[8] = '{8'hC0, 8'h00, 8'h00, 1'b0, 7'd87, 12'hFFF, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1, 8'h58, 8'd0};

    rst     = 1'b0;
    rxData  = 8'h00;
    rxValid = 1'b0;
    txReady = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("resetRxReady", 32'(rxReady), 32'd1);
    checkOutput("resetOutputs",
                32'({txData, txValid, ofsWr, ofsCh, reloadReq, dacWr, dacSel, busy}), 32'd0);
    checkOutput("resetData", 32'({ofsData, dacData, errCount}), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      checkOutput($sformatf("v%0d ofsWr", i), 32'(ofsWr), 32'(vecs[i].ofsWr));
      checkOutput($sformatf("v%0d ofsCh", i), 32'(ofsCh), 32'(vecs[i].ofsCh));
      checkOutput($sformatf("v%0d ofsData", i), 32'(ofsData), 32'(vecs[i].ofsData));
      checkOutput($sformatf("v%0d reload", i), 32'(reloadReq), 32'(vecs[i].reload));
      checkOutput($sformatf("v%0d dacWr", i), 32'(dacWr), 32'(vecs[i].dacWr));
      checkOutput($sformatf("v%0d dacSel", i), 32'(dacSel), 32'(vecs[i].dacSel));
      checkOutput($sformatf("v%0d dacData", i), 32'(dacData), 32'(vecs[i].dacData));
      checkOutput($sformatf("v%0d txValid", i), 32'(txValid), 32'(vecs[i].txValid));
      checkOutput($sformatf("v%0d txData", i), 32'(txData), 32'(vecs[i].txData));
      checkOutput($sformatf("v%0d errCount", i), 32'(errCount), 32'(vecs[i].errCount));
      checkOutput($sformatf("v%0d busy", i), 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d strobesLow", i),
                  32'({ofsWr, reloadReq, dacWr, txValid}), 32'd0);
    end

    // Query held off by the transmitter; an offered rx byte must not be taken.
    txReady = 1'b0;
    applyStimulus(8'hC0, 8'h00, 8'h00);
    checkOutput("bpTxValid", 32'(txValid), 32'd1);
    checkOutput("bpTxData", 32'(txData), 32'h58);
    @(negedge clk);
    rxData  = 8'h81;
    rxValid = 1'b1;
    holdBad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txValid !== 1'b1 || txData !== 8'h58 || rxReady !== 1'b0 || busy !== 1'b0)
        holdBad = 1'b1;
    end
    checkOutput("bpHoldStable", 32'(holdBad), 32'd0);
    rxValid = 1'b0;
    txReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bpTxDrop", 32'(txValid), 32'd0);
    checkOutput("bpRxReady", 32'(rxReady), 32'd1);
    checkOutput("bpErr", 32'(errCount), 32'd0);

    // Resync: a header mid-frame restarts the frame and counts one error.
    sendByte(8'h81);
    applyStimulus(8'hA0, 8'h00, 8'h00);
    checkOutput("resyncReload", 32'(reloadReq), 32'd1);
    checkOutput("resyncErr", 32'(errCount), 32'd1);
    applyStimulus(8'hC1, 8'h00, 8'h00);
    checkOutput("queryErrTx", 32'({txValid, txData}), 32'h101);
    checkOutput("queryErrClr", 32'(errCount), 32'd0);

    // Inter-byte timeout of 100 idle cycles, then the orphan data bytes.
    ofsBefore = ofsPulses;
    sendByte(8'h81);
    repeat (98) @(posedge clk);
    #1;
    checkOutput("toBusyBefore", 32'(busy), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("toBusyAfter", 32'(busy), 32'd0);
    checkOutput("toErr", 32'(errCount), 32'd1);
    sendByte(8'h32);
    checkOutput("toOrphan1Err", 32'(errCount), 32'd2);
    sendByte(8'h55);
    @(negedge clk);
    checkOutput("toOrphan2Err", 32'(errCount), 32'd3);
    checkOutput("toNoOfsWr", 32'(ofsPulses - ofsBefore), 32'd0);

    // Reset mid-frame: everything clears at once and the frame is dropped.
    sendByte(8'h81);
    sendByte(8'h32);
    checkOutput("preResetBusy", 32'(busy), 32'd1);
    ofsBefore = ofsPulses;
    relBefore = reloadPulses;
    dacBefore = dacPulses;
    #3;
    rst = 1'b0;
    #1;
    checkOutput("arstRxReady", 32'(rxReady), 32'd1);
    checkOutput("arstOutputs",
                32'({txData, txValid, ofsWr, ofsCh, reloadReq, dacWr, dacSel, busy}), 32'd0);
    checkOutput("arstData", 32'({ofsData, dacData, errCount}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sendByte(8'h55);
    @(negedge clk);
    checkOutput("postRstErr", 32'(errCount), 32'd1);
    checkOutput("postRstBusy", 32'(busy), 32'd0);
    checkOutput("postRstNoStrobe",
                32'((ofsPulses - ofsBefore) + (reloadPulses - relBefore) + (dacPulses - dacBefore)),
                32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
